mac_seq_driver: RTL
===================

# mac_seq_driver

Transmitter for the three-word serial multiply-accumulate protocol: it accepts one parallel operand triple (a, b, c) on a valid/ready request port and drives it as three consecutive `validi`/`data_in` beats to a serial MAC unit. It then waits for `valido`, captures `data_out`, compares it against an internally computed a*b+c, and returns the result on a valid/ready response port. It sits between a test or command master and the serial MAC datapath.

## Interface
- WIDTH, 32, width of operands and result
- TIMEOUT, 8, maximum WAIT cycles for `valido` before the transaction is aborted (≥ 1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request triple present
- req_ready  out  1  driver can accept a request
- req_a, req_b, req_c  in  WIDTH each  operands
- validi  out  1  serial beat valid, to MAC unit
- data_in  out  WIDTH  serial beat data, to MAC unit
- valido  in  1  result valid, from MAC unit
- data_out  in  WIDTH  result, from MAC unit
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_data  out  WIDTH  captured result (0 on timeout)
- rsp_timeout  out  1  `valido` not seen within TIMEOUT cycles
- rsp_mismatch  out  1  captured `data_out` ≠ expected a*b+c

## Operation
- All outputs registered. Reset values: req_ready=0, validi=0, data_in=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, rsp_mismatch=0, state=IDLE, wait counter=0.
- States: IDLE, SEND_A, SEND_B, SEND_C, WAIT, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, latch a, b, c and go to SEND_A; req_ready drops.
- SEND_A/SEND_B/SEND_C: validi=1, data_in = a / b / c respectively. Unconditional advance, with no stall input.
- WAIT: validi=0, data_in=0. If valido=1, capture data_out into rsp_data, set rsp_mismatch = (data_out ≠ expected), rsp_timeout=0, and go to RESP. Otherwise increment the counter. If the counter reaches TIMEOUT without valido, go to RESP with rsp_timeout=1, rsp_data=0, rsp_mismatch=0.
- RESP: rsp_valid=1. rsp_data, rsp_timeout and rsp_mismatch are held stable until rsp_valid && rsp_ready. On that handshake, go to IDLE and clear rsp_valid.
- expected = (a*b + c) mod 2^WIDTH, unsigned. The product is truncated to WIDTH before the add, and the carry-out is discarded. It is registered no later than entry to WAIT.
- valido outside WAIT is ignored. Only the first valido in WAIT is captured.
- Reset at any cycle overrides everything. On the next edge, all outputs take their reset values and any in-flight transaction is dropped without a response.

## Timing
- Let edge k be the edge where req_valid && req_ready.
- After edge k: validi=1, data_in=a. After k+1: data_in=b. After k+2: data_in=c. After k+3: validi=0 (state WAIT, counter=0). The three beats are strictly consecutive.
- If valido=1 is sampled at edge k+3+n (n ≥ 1, n ≤ TIMEOUT), rsp_valid=1 after that edge.
- If valido is never sampled, rsp_valid=1 with rsp_timeout=1 after edge k+3+TIMEOUT.
- req_ready returns to 1 the cycle after the response handshake edge. Minimum request-to-request spacing is 6 cycles (n=1, rsp_ready held high).
- rsp_valid && rsp_ready in the same cycle that rsp_valid first rises completes on that edge.

## Test plan
- Basic: a=3, b=4, c=5; model asserts valido with data_out=17 two cycles after the last beat → data_in beats 3,4,5 on three consecutive cycles; rsp_data=17, rsp_mismatch=0, rsp_timeout=0.
- Wrap: a=0xFFFFFFFF, b=2, c=3; model returns 0x00000001 → rsp_mismatch=0. Model returns 0x00000002 → rsp_mismatch=1, rsp_data=0x00000002.
- Timeout: a=1, b=1, c=1; valido held 0 → rsp_valid rises exactly after edge k+3+8 with rsp_timeout=1, rsp_data=0; stray valido pulses during SEND_A..SEND_C are ignored.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable, req_ready=0, validi=0 throughout; on rsp_ready=1, IDLE on the next edge.
- Back-to-back: two requests, rsp_ready=1, valido one cycle into WAIT → second beat train starts exactly 6 cycles after the first; both responses correct.
- Reset mid-operation: assert rst while data_in=b → after the next edge, validi=0, data_in=0, req_ready=0, rsp_valid=0; after release, req_ready=1 and no response is ever issued for the aborted request.

Source files
------------

// File: rtl/mac_seq_driver.sv
// Serial multiply-accumulate transmitter: sends an (a, b, c) triple as three
// beats to a serial MAC unit, then returns its result flagged against a*b+c.
module mac_seq_driver #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_c,
  output logic             validi,
  output logic [WIDTH-1:0] data_in,
  input  logic             valido,
  input  logic [WIDTH-1:0] data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic             rsp_mismatch
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEND_A = 3'd1;
  localparam logic [2:0] SEND_B = 3'd2;
  localparam logic [2:0] SEND_C = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] exp_q;
  logic             accept;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // NOTE: operand and expected-result registers carry no reset; they are only
  // read after an accept has loaded them, so reset would add fan-out for nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      b_q   <= req_b;
      c_q   <= req_c;
      exp_q <= req_a * req_b + req_c;
    end
  end

  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready    <= 1'b0;
      validi       <= 1'b0;
      data_in      <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SEND_A;
            req_ready <= 1'b0;
            validi    <= 1'b1;
            data_in   <= req_a;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SEND_A: begin
          state   <= SEND_B;
          data_in <= b_q;
        end
        SEND_B: begin
          state   <= SEND_C;
          data_in <= c_q;
        end
        SEND_C: begin
          state   <= WAIT;
          validi  <= 1'b0;
          data_in <= '0;
          cnt     <= '0;
        end
        WAIT: begin
          if (valido) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_data     <= data_out;
            rsp_timeout  <= 1'b0;
            rsp_mismatch <= (data_out != exp_q);
          end else if (cnt == CNT_LAST) begin
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_data     <= '0;
            rsp_timeout  <= 1'b1;
            rsp_mismatch <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // Raising req_ready on the handshake edge gives the 6-cycle minimum spacing.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
